// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - two-write / two-read register file with per-register pending scoreboard
module rf_multiport #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 2,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              busy1,
    output logic              busy2,
    output logic              stall
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pend;

    logic [DEPTH-1:0]  w_wr_hit;
    logic [DEPTH-1:0]  w_iss_hit;
    logic [ADDR_W-1:0] w_raddr [2];
    logic [DATA_W-1:0] w_rdata [2];
    logic [1:0]        w_busy;

    // Per-register decode; a hard-wired zero register never sees writes or issues.
    always_comb begin
        w_wr_hit  = '0;
        w_iss_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wr_hit[i]  = (we0 && (waddr0 == ADDR_W'(i))) ||
                           (we1 && (waddr1 == ADDR_W'(i)));
            w_iss_hit[i] = issue && (issue_addr == ADDR_W'(i));
            if ((ZERO_R0 != 0) && (i == 0)) begin
                w_wr_hit[i]  = 1'b0;
                w_iss_hit[i] = 1'b0;
            end
        end
    end

    // Port 1 wins a same-address write; a same-edge issue beats the clearing write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_pend <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_hit[i]) begin
                    if (we1 && (waddr1 == ADDR_W'(i))) begin
                        r_mem[i] <= wdata1;
                    end else begin
                        r_mem[i] <= wdata0;
                    end
                end
                if (w_iss_hit[i]) begin
                    r_pend[i] <= 1'b1;
                end else if (w_wr_hit[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    assign w_raddr[0] = raddr1;
    assign w_raddr[1] = raddr2;

    // Storage and pending bits are already zero during reset; forwarding is gated by reset_n.
    always_comb begin
        w_busy = '0;
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = r_mem[w_raddr[p]];
            w_busy[p]  = r_pend[w_raddr[p]];
            if ((BYPASS != 0) && reset_n && w_wr_hit[w_raddr[p]]) begin
                w_busy[p] = r_pend[w_raddr[p]] && w_iss_hit[w_raddr[p]];
                if (we1 && (waddr1 == w_raddr[p])) begin
                    w_rdata[p] = wdata1;
                end else begin
                    w_rdata[p] = wdata0;
                end
            end
            if ((ZERO_R0 != 0) && (w_raddr[p] == '0)) begin
                w_rdata[p] = '0;
                w_busy[p]  = 1'b0;
            end
        end
    end

    assign rdata1 = w_rdata[0];
    assign rdata2 = w_rdata[1];
    assign busy1  = w_busy[0];
    assign busy2  = w_busy[1];
    assign stall  = w_busy[0] | w_busy[1];

endmodule

// File: tb/tb_rf_multiport.sv
// tb/tb_rf_multiport.sv - directed checks of rf_multiport across bypass, zero-r0 and wide configurations
module tb_rf_multiport;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we0, we1, issue;
    logic [1:0]  waddr0, waddr1, raddr1, raddr2, issue_addr;
    logic [15:0] wdata0, wdata1;

    logic [15:0] d_rdata1, d_rdata2, n_rdata1, n_rdata2, z_rdata1, z_rdata2;
    logic        d_busy1, d_busy2, d_stall;
    logic        n_busy1, n_busy2, n_stall;
    logic        z_busy1, z_busy2, z_stall;

    logic        w_rst_n;
    logic        w_we0, w_we1, w_issue;
    logic [2:0]  w_waddr0, w_waddr1, w_raddr1, w_raddr2, w_issue_addr;
    logic [31:0] w_wdata0, w_wdata1, w_rdata1, w_rdata2;
    logic        w_busy1, w_busy2, w_stall;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rf_multiport #(.DATA_W(16), .ADDR_W(2), .ZERO_R0(0), .BYPASS(1)) u_dflt (
        .clk(clk), .reset_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(d_rdata1), .rdata2(d_rdata2),
        .issue(issue), .issue_addr(issue_addr),
        .busy1(d_busy1), .busy2(d_busy2), .stall(d_stall));

    rf_multiport #(.DATA_W(16), .ADDR_W(2), .ZERO_R0(0), .BYPASS(0)) u_nobyp (
        .clk(clk), .reset_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(n_rdata1), .rdata2(n_rdata2),
        .issue(issue), .issue_addr(issue_addr),
        .busy1(n_busy1), .busy2(n_busy2), .stall(n_stall));

    rf_multiport #(.DATA_W(16), .ADDR_W(2), .ZERO_R0(1), .BYPASS(1)) u_zero (
        .clk(clk), .reset_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(z_rdata1), .rdata2(z_rdata2),
        .issue(issue), .issue_addr(issue_addr),
        .busy1(z_busy1), .busy2(z_busy2), .stall(z_stall));

    rf_multiport #(.DATA_W(32), .ADDR_W(3), .ZERO_R0(0), .BYPASS(1)) u_wide (
        .clk(clk), .reset_n(w_rst_n),
        .we0(w_we0), .waddr0(w_waddr0), .wdata0(w_wdata0),
        .we1(w_we1), .waddr1(w_waddr1), .wdata1(w_wdata1),
        .raddr1(w_raddr1), .raddr2(w_raddr2), .rdata1(w_rdata1), .rdata2(w_rdata2),
        .issue(w_issue), .issue_addr(w_issue_addr),
        .busy1(w_busy1), .busy2(w_busy2), .stall(w_stall));

    task automatic idle_inputs();
        we0 = 0; we1 = 0; issue = 0;
        waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; issue_addr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; w_rst_n = 0;
        idle_inputs();
        raddr1 = 0; raddr2 = 0;
        repeat (2) @(negedge clk);
        we1 = 1; waddr1 = 1; wdata1 = 16'h5555; issue = 1; issue_addr = 1; raddr1 = 1; raddr2 = 1;
        #1;
        n_cmp++; if (d_rdata1 !== 16'h0000) begin n_fail++; $display("FAIL rst_no_bypass: got %h want 0000", d_rdata1); end
        n_cmp++; if (d_busy1 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", d_busy1); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (d_rdata1 !== 16'h0000) begin n_fail++; $display("FAIL rst_write_ignored: got %h want 0000", d_rdata1); end
        for (int a = 0; a < 4; a++) begin
            raddr1 = 2'(a); raddr2 = 2'(a);
            #1;
            n_cmp++; if (d_rdata1 !== 16'h0000 || d_rdata2 !== 16'h0000 || d_stall !== 1'b0) begin
                n_fail++; $display("FAIL rst_read[%0d]: got %h/%h stall %b want 0000/0000 stall 0", a, d_rdata1, d_rdata2, d_stall);
            end
        end
        @(negedge clk);
        rst_n = 1; w_rst_n = 1;
    endtask

    task automatic test_nobypass_read();
        @(negedge clk);
        we0 = 1; waddr0 = 1; wdata0 = 16'h00FF; raddr1 = 1;
        #1;
        n_cmp++; if (n_rdata1 !== 16'h0000) begin n_fail++; $display("FAIL nobyp_old: got %h want 0000", n_rdata1); end
        n_cmp++; if (d_rdata1 !== 16'h00FF) begin n_fail++; $display("FAIL byp_fwd0: got %h want 00ff", d_rdata1); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (n_rdata1 !== 16'h00FF) begin n_fail++; $display("FAIL nobyp_new: got %h want 00ff", n_rdata1); end
    endtask

    task automatic test_dual_write_same();
        @(negedge clk);
        we0 = 1; waddr0 = 2; wdata0 = 16'h1234;
        we1 = 1; waddr1 = 2; wdata1 = 16'hABCD; raddr1 = 2;
        #1;
        n_cmp++; if (d_rdata1 !== 16'hABCD) begin n_fail++; $display("FAIL same_byp: got %h want abcd", d_rdata1); end
        n_cmp++; if (n_rdata1 !== 16'h0000) begin n_fail++; $display("FAIL same_nobyp_old: got %h want 0000", n_rdata1); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (d_rdata1 !== 16'hABCD) begin n_fail++; $display("FAIL same_store: got %h want abcd", d_rdata1); end
        n_cmp++; if (n_rdata1 !== 16'hABCD) begin n_fail++; $display("FAIL same_store_nb: got %h want abcd", n_rdata1); end
    endtask

    task automatic test_dual_write_diff();
        @(negedge clk);
        we0 = 1; waddr0 = 1; wdata0 = 16'h1111;
        we1 = 1; waddr1 = 3; wdata1 = 16'h3333; raddr1 = 1; raddr2 = 3;
        #1;
        n_cmp++; if (d_rdata1 !== 16'h1111 || d_rdata2 !== 16'h3333) begin
            n_fail++; $display("FAIL diff_byp: got %h/%h want 1111/3333", d_rdata1, d_rdata2);
        end
        n_cmp++; if (n_rdata1 !== 16'h00FF || n_rdata2 !== 16'h0000) begin
            n_fail++; $display("FAIL diff_nobyp_old: got %h/%h want 00ff/0000", n_rdata1, n_rdata2);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (n_rdata1 !== 16'h1111 || n_rdata2 !== 16'h3333) begin
            n_fail++; $display("FAIL diff_store: got %h/%h want 1111/3333", n_rdata1, n_rdata2);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        issue = 1; issue_addr = 3; raddr1 = 2; raddr2 = 3;
        #1;
        n_cmp++; if (d_busy2 !== 1'b0) begin n_fail++; $display("FAIL sb_not_yet: got %b want 0", d_busy2); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (d_busy2 !== 1'b1 || d_stall !== 1'b1) begin
            n_fail++; $display("FAIL sb_pending: busy2 %b stall %b want 1 1", d_busy2, d_stall);
        end
        we0 = 1; waddr0 = 3; wdata0 = 16'h7777;
        #1;
        n_cmp++; if (d_busy2 !== 1'b0 || d_stall !== 1'b0) begin
            n_fail++; $display("FAIL sb_byp_clear: busy2 %b stall %b want 0 0", d_busy2, d_stall);
        end
        n_cmp++; if (n_busy2 !== 1'b1 || n_stall !== 1'b1) begin
            n_fail++; $display("FAIL sb_nobyp_hold: busy2 %b stall %b want 1 1", n_busy2, n_stall);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (d_stall !== 1'b0 || n_stall !== 1'b0 || n_busy2 !== 1'b0) begin
            n_fail++; $display("FAIL sb_cleared: stall %b/%b busy2 %b want 0/0 0", d_stall, n_stall, n_busy2);
        end
    endtask

    task automatic test_issue_and_write();
        @(negedge clk);
        issue = 1; issue_addr = 1; we0 = 1; waddr0 = 1; wdata0 = 16'h4444; raddr1 = 1; raddr2 = 3;
        #1;
        n_cmp++; if (d_busy1 !== 1'b0) begin n_fail++; $display("FAIL iw_before: got %b want 0", d_busy1); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (d_busy1 !== 1'b1 || n_busy1 !== 1'b1 || d_rdata1 !== 16'h4444) begin
            n_fail++; $display("FAIL iw_set: busy1 %b/%b data %h want 1/1 4444", d_busy1, n_busy1, d_rdata1);
        end
        issue = 1; issue_addr = 1; we1 = 1; waddr1 = 1; wdata1 = 16'h5555;
        #1;
        n_cmp++; if (d_busy1 !== 1'b1) begin n_fail++; $display("FAIL iw_reissue_busy: got %b want 1", d_busy1); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (d_busy1 !== 1'b1) begin n_fail++; $display("FAIL iw_reissue_set: got %b want 1", d_busy1); end
        we1 = 1; waddr1 = 1; wdata1 = 16'h6666;
        #1;
        n_cmp++; if (d_busy1 !== 1'b0 || n_busy1 !== 1'b1) begin
            n_fail++; $display("FAIL iw_wb: busy1 %b/%b want 0/1", d_busy1, n_busy1);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (d_stall !== 1'b0 || n_stall !== 1'b0 || n_rdata1 !== 16'h6666) begin
            n_fail++; $display("FAIL iw_done: stall %b/%b data %h want 0/0 6666", d_stall, n_stall, n_rdata1);
        end
    endtask

    task automatic test_zero_r0();
        @(negedge clk);
        we1 = 1; waddr1 = 0; wdata1 = 16'hFFFF; issue = 1; issue_addr = 0; raddr1 = 0; raddr2 = 0;
        #1;
        n_cmp++; if (z_rdata1 !== 16'h0000 || z_busy1 !== 1'b0) begin
            n_fail++; $display("FAIL z_same: data %h busy %b want 0000 0", z_rdata1, z_busy1);
        end
        n_cmp++; if (d_rdata1 !== 16'hFFFF) begin n_fail++; $display("FAIL z_ref_byp: got %h want ffff", d_rdata1); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (z_rdata1 !== 16'h0000 || z_busy1 !== 1'b0 || z_stall !== 1'b0) begin
            n_fail++; $display("FAIL z_after: data %h busy %b stall %b want 0000 0 0", z_rdata1, z_busy1, z_stall);
        end
        n_cmp++; if (d_rdata1 !== 16'hFFFF || d_busy1 !== 1'b1) begin
            n_fail++; $display("FAIL z_ref_after: data %h busy %b want ffff 1", d_rdata1, d_busy1);
        end
    endtask

    task automatic test_reset_midwrite();
        @(negedge clk);
        we1 = 1; waddr1 = 2; wdata1 = 16'h9999; raddr1 = 2; raddr2 = 0;
        #3;
        rst_n = 0;
        #1;
        n_cmp++; if (d_rdata1 !== 16'h0000 || d_stall !== 1'b0) begin
            n_fail++; $display("FAIL mid_async: data %h stall %b want 0000 0", d_rdata1, d_stall);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        #1;
        n_cmp++; if (d_rdata1 !== 16'h0000) begin n_fail++; $display("FAIL mid_discard: got %h want 0000", d_rdata1); end
        we0 = 1; waddr0 = 2; wdata0 = 16'h0202;
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (n_rdata1 !== 16'h0202) begin n_fail++; $display("FAIL first_write: got %h want 0202", n_rdata1); end
    endtask

    task automatic test_wide();
        w_raddr1 = 0; w_raddr2 = 0;
        @(negedge clk);
        w_we0 = 1; w_waddr0 = 7; w_wdata0 = 32'hDEADBEEF;
        w_we1 = 1; w_waddr1 = 0; w_wdata1 = 32'h1;
        w_issue = 1; w_issue_addr = 5;
        @(negedge clk);
        w_we0 = 0; w_we1 = 0; w_issue = 0;
        w_raddr1 = 7; w_raddr2 = 5;
        #1;
        n_cmp++; if (w_rdata1 !== 32'hDEADBEEF || w_busy2 !== 1'b1 || w_stall !== 1'b1) begin
            n_fail++; $display("FAIL wide_write: data %h busy2 %b stall %b want deadbeef 1 1", w_rdata1, w_busy2, w_stall);
        end
        w_raddr1 = 0;
        #1;
        n_cmp++; if (w_rdata1 !== 32'h1) begin n_fail++; $display("FAIL wide_r0: got %h want 00000001", w_rdata1); end
        #1;
        w_rst_n = 0;
        #1;
        n_cmp++; if (w_rdata1 !== 32'h0 || w_busy2 !== 1'b0 || w_stall !== 1'b0) begin
            n_fail++; $display("FAIL wide_rst: data %h busy2 %b stall %b want 0 0 0", w_rdata1, w_busy2, w_stall);
        end
        @(negedge clk);
        w_raddr1 = 7;
        #1;
        n_cmp++; if (w_rdata1 !== 32'h0) begin n_fail++; $display("FAIL wide_rst_r7: got %h want 0", w_rdata1); end
        w_rst_n = 1;
        #1;
        n_cmp++; if (w_rdata1 !== 32'h0 || w_busy2 !== 1'b0) begin
            n_fail++; $display("FAIL wide_post_rst: data %h busy2 %b want 0 0", w_rdata1, w_busy2);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0; w_rst_n = 0; raddr1 = 0; raddr2 = 0;
        w_we0 = 0; w_we1 = 0; w_issue = 0;
        w_waddr0 = 0; w_waddr1 = 0; w_wdata0 = 0; w_wdata1 = 0;
        w_raddr1 = 0; w_raddr2 = 0; w_issue_addr = 0;
        test_reset();
        test_nobypass_read();
        test_dual_write_same();
        test_dual_write_diff();
        test_scoreboard();
        test_issue_and_write();
        test_zero_r0();
        test_reset_midwrite();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_multiport.md
RF_MULTIPORT -- requirements
Module: rf_multiport

Interface
REQ-001 Parameter DATA_W, default 16, bit width of each register.
REQ-002 Parameter ADDR_W, default 2, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_R0, default 0, when 1 register 0 reads as zero and ignores writes.
REQ-004 Parameter BYPASS, default 1, when 1 same-cycle write data is forwarded to read ports.
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 we0  in  1  write enable, port 0.
REQ-008 waddr0  in  ADDR_W  write address, port 0.
REQ-009 wdata0  in  DATA_W  write data, port 0.
REQ-010 we1  in  1  write enable, port 1 (priority port).
REQ-011 waddr1  in  ADDR_W  write address, port 1.
REQ-012 wdata1  in  DATA_W  write data, port 1.
REQ-013 raddr1, raddr2  in  ADDR_W each  read addresses (rs, rt).
REQ-014 rdata1, rdata2  out  DATA_W each  read data.
REQ-015 issue  in  1  mark register issue_addr as pending (result in flight).
REQ-016 issue_addr  in  ADDR_W  destination register being issued.
REQ-017 busy1, busy2  out  1 each  pending flag of raddr1 / raddr2.
REQ-018 stall  out  1  busy1 OR busy2.

Function
REQ-019 Storage: DEPTH x DATA_W registers, written on posedge clk only.
REQ-020 we0 alone writes wdata0 to waddr0; we1 alone writes wdata1 to waddr1.
REQ-021 we0 and we1 to different addresses: both written same edge.
REQ-022 we0 and we1 to same address: wdata1 written, wdata0 discarded.
REQ-023 Reads combinational; BYPASS=0: rdata = stored value (new data visible the cycle after write edge).
REQ-024 BYPASS=1: rdata = wdata1 if we1 and waddr1 match; else wdata0 if we0 and waddr0 match; else stored value.
REQ-025 ZERO_R0=1: writes to address 0 suppressed (both ports, no bypass), reads of address 0 return 0, address 0 never pending.
REQ-026 Scoreboard: one pending bit per register.
REQ-027 Pending bit set at edge where issue=1 and issue_addr selects it.
REQ-028 Pending bit cleared at edge where any write enable targets it.
REQ-029 issue and write to same address same edge: bit ends set (new producer wins).
REQ-030 busy1/busy2 = pending bit of raddr1/raddr2, combinational; BYPASS=1 and a same-cycle write to that address forces busy low unless issue also targets it.
REQ-031 Write without prior issue is legal; pending bit stays/becomes 0.
REQ-032 Out-of-range addresses impossible (DEPTH = 2**ADDR_W); no error signalling.

Reset
REQ-033 reset_n=0 clears all registers to 0 and all pending bits to 0 immediately, independent of clk.
REQ-034 During reset, writes and issues ignored; rdata1/rdata2 = 0 (BYPASS forwarding of wdata allowed only when reset_n=1), busy1/busy2/stall = 0.
REQ-035 First write accepted at first posedge with reset_n=1; reset asserted mid-write discards that write.

Verification
REQ-036 Defaults; reset, then read all addresses -> rdata1=rdata2=16'h0000, stall=0.
REQ-037 we0=1 waddr0=2 wdata0=16'h1234 and we1=1 waddr1=2 wdata1=16'hABCD, same edge -> next cycle raddr1=2 reads 16'hABCD; BYPASS=1 same cycle already reads 16'hABCD.
REQ-038 BYPASS=0: we0 waddr0=1 wdata0=16'h00FF, raddr1=1 same cycle -> old value 16'h0000; after edge -> 16'h00FF.
REQ-039 issue issue_addr=3; next cycle raddr2=3 -> busy2=1, stall=1; we0 waddr0=3 -> with BYPASS=1 busy2=0 same cycle, after edge pending cleared, stall=0.
REQ-040 ZERO_R0=1: we1 waddr1=0 wdata1=16'hFFFF, issue issue_addr=0 -> raddr1=0 reads 16'h0000, busy1=0.
REQ-041 DATA_W=32, ADDR_W=3: write 32'hDEADBEEF to 7 and 32'h1 to 0 same edge, then assert reset_n=0 between edges -> all reads 0 immediately, pending cleared.
